nerv_access_ctrl: RTL and testbench
===================================

# nerv_access_ctrl

Sequencing controller for the NERV password lock. It accepts 16-bit password attempts on the chip-select/read/write bus and compares them against a programmable key. It counts failed attempts and enforces a timed lockout. While unlocked, it gates access to a 16-bit protected data register, which it returns on `lock`, and it relocks automatically after a period of bus inactivity.

## Interface
Parameters:
- `KEY_RESET`, 16'd5423, key value loaded at reset.
- `MAX_TRIES`, 3, consecutive failures that trigger lockout (≥1).
- `OPEN_CYCLES`, 30, idle cycles in OPEN before auto-relock (≥1).
- `LOCKOUT_CYCLES`, 1000, cycles spent in LOCKOUT (≥1).

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `cs`  in  1  chip select; `rd`/`wr` are ignored unless `cs`=1.
- `wr`  in  1  write strobe; sampled each cycle and treated as level-per-cycle.
- `rd`  in  1  read strobe.
- `prog`  in  1  qualifies a write in OPEN as a key change.
- `data_in`  in  16  password attempt, data word or new key.
- `lock`  out  16  protected read data; 0 when not valid.
- `pass`  out  1  one-cycle pulse on a correct password.
- `fail`  out  1  one-cycle pulse on a wrong password.
- `unlocked`  out  1  high while in OPEN.
- `lockout`  out  1  high while in LOCKOUT.
- `fail_cnt`  out  $clog2(MAX_TRIES+1)  current consecutive-failure count.

## Operation
- States and transitions:
  - LOCKED: `cs&wr` captures `data_in` into `attempt` and moves to CHECK. `rd` is ignored and `lock` stays 0.
  - CHECK (exactly 1 cycle): all bus accesses are ignored.
    - `attempt==key`: pulse `pass`, clear `fail_cnt`, load the open timer, go to OPEN.
    - Otherwise: pulse `fail`, increment `fail_cnt`.
      - If the new `fail_cnt` equals `MAX_TRIES`: load the lockout timer, go to LOCKOUT.
      - Else: go to LOCKED.
  - OPEN:
    - `cs&wr&!prog` writes `data_in` to `data_reg`.
    - `cs&wr&prog` writes `data_in` to `key`.
    - `cs&rd&!wr` loads `lock` with `data_reg`.
    - `cs&wr&rd` together: the write wins and the read is dropped.
    - Any accepted access reloads the open timer.
    - Timer expiry moves to LOCKED and clears `lock` to 0.
  - LOCKOUT: all accesses are ignored. On timer expiry, clear `fail_cnt` and go to LOCKED.
- Timers:
  - A single down-counter is shared by OPEN and LOCKOUT.
  - Width is $clog2(max(OPEN_CYCLES, LOCKOUT_CYCLES)+1).
  - Loaded with N-1 and decremented each cycle; the state exits on the edge where the count is 0.
- Key and data:
  - The new key takes effect on the next password check; the current OPEN session is not affected.
  - `data_reg` persists across lock/unlock and is cleared only by reset.
- Reset values (asynchronous on `reset`=0):
  - state=LOCKED, `key`=KEY_RESET.
  - `data_reg`, `attempt`, timer and `fail_cnt` are 0.
  - All outputs are 0.
- Reset asserted mid-operation (CHECK, OPEN or LOCKOUT) returns to LOCKED immediately. Any key change is lost.

## Timing
- All outputs are registered.
- Password latency: write accepted at edge E0; CHECK during cycle E0..E1; at E1 the state becomes OPEN or LOCKED or LOCKOUT. `pass`/`fail` are high for the cycle E1..E2. `unlocked` or `lockout` rises at E1.
- Read latency: `rd` accepted at edge E0; `lock` is valid from E0 and holds until the next accepted read or exit from OPEN.
- With no accesses, OPEN lasts exactly OPEN_CYCLES cycles and LOCKOUT lasts exactly LOCKOUT_CYCLES cycles. `unlocked` and `lockout` then fall on the exit edge.
- A write in the last OPEN cycle (timer = 0) is accepted and keeps the state in OPEN.
- Back-to-back writes in LOCKED: only the first is captured. The one arriving during CHECK is dropped.

## Test plan
- Correct key: reset, `cs=1 wr=1 data_in=5423` for one cycle → `pass` pulses 2 edges later, `unlocked=1`, `fail_cnt=0`.
- Data access: unlock, write 16'hBEEF, then `rd` → `lock=16'hBEEF` the next cycle. After 30 idle cycles `unlocked=0` and `lock=0`.
- Lockout: three writes of 16'd1111 → `fail` pulses each time and `fail_cnt` goes 1, 2, 3, then `lockout=1`. A write of 5423 during LOCKOUT is ignored. After 1000 cycles `lockout=0` and `fail_cnt=0`.
- Failure counter clear: two wrong attempts, then 5423 → `pass`, `fail_cnt=0`.
- Key change: unlock, `prog=1` write 16'h1234, wait for relock. 5423 → `fail`; 16'h1234 → `pass`.
- Reset mid-OPEN after a key change: assert `reset`=0 → all outputs 0, state LOCKED. 5423 is accepted again.

Source files
------------

// File: rtl/nerv_access_ctrl.sv
// NERV password lock sequencer: checks 16-bit attempts against a programmable key,
// enforces a timed lockout after repeated failures and gates a protected data register.
module nerv_access_ctrl #(
   parameter logic [15:0] KEY_RESET      = 16'd5423,
   parameter int unsigned MAX_TRIES      = 3,
   parameter int unsigned OPEN_CYCLES    = 30,
   parameter int unsigned LOCKOUT_CYCLES = 1000,
   localparam int unsigned CntW   = $clog2(MAX_TRIES + 1),
   localparam int unsigned TmrMax = (OPEN_CYCLES > LOCKOUT_CYCLES) ? OPEN_CYCLES
                                                                    : LOCKOUT_CYCLES,
   localparam int unsigned TmrW   = $clog2(TmrMax + 1)
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            cs,
   input  logic            wr,
   input  logic            rd,
   input  logic            prog,
   input  logic [15:0]     data_in,
   output logic [15:0]     lock,
   output logic            pass,
   output logic            fail,
   output logic            unlocked,
   output logic            lockout,
   output logic [CntW-1:0] fail_cnt
);

   localparam logic [TmrW-1:0] OpenLoad = TmrW'(OPEN_CYCLES - 1);
   localparam logic [TmrW-1:0] LockLoad = TmrW'(LOCKOUT_CYCLES - 1);
   localparam logic [CntW-1:0] MaxCnt   = CntW'(MAX_TRIES);

   typedef enum logic [1:0] {
      StLocked,
      StCheck,
      StOpen,
      StLockout
   } state_e;

   state_e          state_q, state_d;
   logic [15:0]     key_q, key_d;
   logic [15:0]     data_q, data_d;
   logic [15:0]     attempt_q, attempt_d;
   logic [TmrW-1:0] timer_q, timer_d;
   logic [CntW-1:0] cnt_q, cnt_d;
   logic [15:0]     lock_q, lock_d;
   logic            pass_q, pass_d;
   logic            fail_q, fail_d;
   logic            unlocked_q, unlocked_d;
   logic            lockout_q, lockout_d;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= StLocked;
         key_q      <= KEY_RESET;
         data_q     <= '0;
         attempt_q  <= '0;
         timer_q    <= '0;
         cnt_q      <= '0;
         lock_q     <= '0;
         pass_q     <= 1'b0;
         fail_q     <= 1'b0;
         unlocked_q <= 1'b0;
         lockout_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         key_q      <= key_d;
         data_q     <= data_d;
         attempt_q  <= attempt_d;
         timer_q    <= timer_d;
         cnt_q      <= cnt_d;
         lock_q     <= lock_d;
         pass_q     <= pass_d;
         fail_q     <= fail_d;
         unlocked_q <= unlocked_d;
         lockout_q  <= lockout_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      key_d     = key_q;
      data_d    = data_q;
      attempt_d = attempt_q;
      timer_d   = timer_q;
      cnt_d     = cnt_q;
      lock_d    = lock_q;
      pass_d    = 1'b0;
      fail_d    = 1'b0;

      unique case (state_q)
         StLocked: begin
            if (cs && wr) begin
               attempt_d = data_in;
               state_d   = StCheck;
            end
         end

         StCheck: begin
            if (attempt_q == key_q) begin
               pass_d  = 1'b1;
               cnt_d   = '0;
               timer_d = OpenLoad;
               state_d = StOpen;
            end else begin
               fail_d = 1'b1;
               cnt_d  = cnt_q + CntW'(1);
               if (cnt_d == MaxCnt) begin
                  timer_d = LockLoad;
                  state_d = StLockout;
               end else begin
                  state_d = StLocked;
               end
            end
         end

         StOpen: begin
            // Write beats a simultaneous read; any accepted access restarts the idle timer,
            // including one landing in the final cycle.
            if (cs && wr) begin
               if (prog) begin
                  key_d = data_in;
               end else begin
                  data_d = data_in;
               end
               timer_d = OpenLoad;
            end else if (cs && rd) begin
               lock_d  = data_q;
               timer_d = OpenLoad;
            end else if (timer_q == '0) begin
               lock_d  = '0;
               state_d = StLocked;
            end else begin
               timer_d = timer_q - TmrW'(1);
            end
         end

         StLockout: begin
            if (timer_q == '0) begin
               cnt_d   = '0;
               state_d = StLocked;
            end else begin
               timer_d = timer_q - TmrW'(1);
            end
         end

         default: state_d = StLocked;
      endcase

      // Status flags track the state being entered so they change on the same edge.
      unlocked_d = (state_d == StOpen);
      lockout_d  = (state_d == StLockout);
   end

   assign lock     = lock_q;
   assign pass     = pass_q;
   assign fail     = fail_q;
   assign unlocked = unlocked_q;
   assign lockout  = lockout_q;
   assign fail_cnt = cnt_q;

endmodule

// File: tb/tb_nerv_access_ctrl.sv
// Bench for nerv_access_ctrl: password results are scoreboarded against a small key/failure
// model; bus and timer behaviour is checked directly at negedges.
module tb_nerv_access_ctrl;

   logic        clk = 1'b0;
   logic        reset;
   logic        cs, wr, rd, prog;
   logic [15:0] data_in;
   logic [15:0] lock;
   logic        pass, fail, unlocked, lockout;
   logic [1:0]  fail_cnt;

   nerv_access_ctrl dut (
      .clk      (clk),
      .reset    (reset),
      .cs       (cs),
      .wr       (wr),
      .rd       (rd),
      .prog     (prog),
      .data_in  (data_in),
      .lock     (lock),
      .pass     (pass),
      .fail     (fail),
      .unlocked (unlocked),
      .lockout  (lockout),
      .fail_cnt (fail_cnt)
   );

   always #5 clk = ~clk;

   int unsigned n_tests = 0;
   int unsigned n_fail  = 0;
   int unsigned cyc     = 0;

   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic        is_pass;
      logic [1:0]  cnt;
      logic        unl;
      logic        lko;
      int unsigned due;
   } exp_t;

   exp_t        sb[$];
   exp_t        mon_e;
   logic [15:0] m_key;
   int unsigned m_cnt;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   always @(negedge clk) begin
      if (reset && (pass || fail)) begin
         if (sb.size() == 0) begin
            check_eq("unexpected_pulse", {30'd0, pass, fail}, 32'd0);
         end else begin
            mon_e = sb.pop_front();
            check_eq("pulse_cycle", cyc, mon_e.due);
            check_eq("pass", {31'd0, pass}, {31'd0, mon_e.is_pass});
            check_eq("fail", {31'd0, fail}, {31'd0, !mon_e.is_pass});
            check_eq("fail_cnt", {30'd0, fail_cnt}, {30'd0, mon_e.cnt});
            check_eq("unlocked", {31'd0, unlocked}, {31'd0, mon_e.unl});
            check_eq("lockout", {31'd0, lockout}, {31'd0, mon_e.lko});
         end
      end
   end

   // Password attempt from LOCKED; hold=2 keeps wr high through CHECK. Returns at the
   // negedge after the result edge.
   task automatic attempt(input logic [15:0] v, input int hold);
      exp_t e;
      if (v == m_key) begin
         m_cnt     = 0;
         e.is_pass = 1'b1;
         e.unl     = 1'b1;
         e.lko     = 1'b0;
      end else begin
         m_cnt++;
         e.is_pass = 1'b0;
         e.unl     = 1'b0;
         e.lko     = (m_cnt == 3);
      end
      e.cnt   = 2'(m_cnt);
      e.due   = cyc + 2;
      cs      = 1'b1;
      wr      = 1'b1;
      data_in = v;
      sb.push_back(e);
      repeat (hold) @(negedge clk);
      cs = 1'b0;
      wr = 1'b0;
      if (hold < 2) @(negedge clk);
   endtask

   task automatic bus(input logic w, input logic r, input logic p, input logic [15:0] v);
      cs      = 1'b1;
      wr      = w;
      rd      = r;
      prog    = p;
      data_in = v;
      @(negedge clk);
      cs   = 1'b0;
      wr   = 1'b0;
      rd   = 1'b0;
      prog = 1'b0;
   endtask

   task automatic check_all_zero(input string tag);
      check_eq({tag, "_lock"}, {16'd0, lock}, 32'd0);
      check_eq({tag, "_flags"}, {28'd0, pass, fail, unlocked, lockout}, 32'd0);
      check_eq({tag, "_fail_cnt"}, {30'd0, fail_cnt}, 32'd0);
   endtask

   initial begin
      #500000;
      $display("FAIL timeout: bench did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      reset   = 1'b0;
      cs      = 1'b0;
      wr      = 1'b0;
      rd      = 1'b0;
      prog    = 1'b0;
      data_in = '0;
      m_key   = 16'd5423;
      m_cnt   = 0;
      repeat (2) @(negedge clk);
      check_all_zero("reset");
      reset = 1'b1;
      @(negedge clk);

      // Correct key, then data access with write-over-read priority.
      attempt(16'd5423, 1);
      bus(1'b1, 1'b0, 1'b0, 16'hBEEF);
      bus(1'b0, 1'b1, 1'b0, 16'h0000);
      check_eq("read_beef", {16'd0, lock}, 32'h0000BEEF);
      bus(1'b1, 1'b1, 1'b0, 16'h1111);
      check_eq("wr_wins_lock_held", {16'd0, lock}, 32'h0000BEEF);
      bus(1'b0, 1'b1, 1'b0, 16'h0000);
      check_eq("read_1111", {16'd0, lock}, 32'h00001111);
      bus(1'b1, 1'b0, 1'b0, 16'hBEEF);
      bus(1'b0, 1'b1, 1'b0, 16'h0000);
      check_eq("read_beef2", {16'd0, lock}, 32'h0000BEEF);
      repeat (29) @(negedge clk);
      check_eq("open_last_cycle", {31'd0, unlocked}, 32'd1);
      @(negedge clk);
      check_eq("relock_unlocked", {31'd0, unlocked}, 32'd0);
      check_eq("relock_lock", {16'd0, lock}, 32'd0);
      bus(1'b0, 1'b1, 1'b0, 16'h0000);
      check_eq("rd_in_locked", {16'd0, lock}, 32'd0);

      // Three failures into lockout; correct key ignored while locked out.
      attempt(16'd1111, 1);
      attempt(16'd1111, 1);
      attempt(16'd1111, 1);
      bus(1'b1, 1'b0, 1'b0, 16'd5423);
      check_eq("lockout_ignores_wr", {31'd0, lockout}, 32'd1);
      repeat (998) @(negedge clk);
      check_eq("lockout_last_cycle", {31'd0, lockout}, 32'd1);
      @(negedge clk);
      check_eq("lockout_exit", {31'd0, lockout}, 32'd0);
      check_eq("lockout_cnt_clear", {30'd0, fail_cnt}, 32'd0);
      m_cnt = 0;

      // Write held through CHECK is dropped; then counter clears on pass.
      attempt(16'd1111, 2);
      attempt(16'd1111, 1);
      attempt(16'd5423, 1);

      // Key change, plus a write in the final OPEN cycle extending the session.
      bus(1'b1, 1'b0, 1'b1, 16'h1234);
      m_key = 16'h1234;
      repeat (29) @(negedge clk);
      bus(1'b1, 1'b0, 1'b0, 16'h5555);
      check_eq("last_cycle_write_stays_open", {31'd0, unlocked}, 32'd1);
      repeat (30) @(negedge clk);
      check_eq("relock_after_key_change", {31'd0, unlocked}, 32'd0);
      attempt(16'd5423, 1);
      attempt(16'h1234, 1);
      bus(1'b0, 1'b1, 1'b0, 16'h0000);
      check_eq("data_persists", {16'd0, lock}, 32'h00005555);

      // Asynchronous reset mid-OPEN after another key change.
      bus(1'b1, 1'b0, 1'b1, 16'hAAAA);
      reset = 1'b0;
      #1;
      check_all_zero("async_reset");
      @(negedge clk);
      reset = 1'b1;
      m_key = 16'd5423;
      m_cnt = 0;
      @(negedge clk);
      attempt(16'hAAAA, 1);
      attempt(16'd5423, 1);
      bus(1'b0, 1'b1, 1'b0, 16'h0000);
      check_eq("data_cleared_by_reset", {16'd0, lock}, 32'd0);

      repeat (3) @(negedge clk);
      check_eq("sb_empty", sb.size(), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
